mat_collect: RTL

// - Deserialiser: accepts one fixed-point scalar per handshake in row-major order and assembles a ROWS x COLS matrix.
// - Presents the matrix with valid/ready to the next stage: a matrix operator, or the debug print monitor via its valid.
// - Sits between scalar producers (stimulus ROM, UART loader, streaming arithmetic) and matrix-wide consumers.

---
 rtl/mat_collect_if.sv | 33 +++
 rtl/mat_collect.sv | 99 +++++++++
 2 files changed

// File: rtl/mat_collect_if.sv
// fixedp: clock/reset plus the scalar-in / matrix-out stream of a fixed-point matrix stage.
// ROWS/COLS here must match the parameters of the attached mat_collect.
interface fixedp #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 2,
  parameter int COLS  = 2
) (
  input logic clk,
  input logic reset
);
  logic                            in_valid;
  logic                            in_ready;
  logic [WIDTH-1:0]                in_data;
  logic                            in_last;
  logic                            out_valid;
  logic                            out_ready;
  logic [ROWS:1][COLS:1][WIDTH-1:0] o;
  logic                            err;

  // Producer/consumer side: feeds scalars, takes matrices.
  modport master (
    input  clk, reset,
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, o, err
  );

  // Collector side.
  modport slave (
    input  clk, reset,
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, o, err
  );
endinterface

// File: rtl/mat_collect.sv
// mat_collect: row-major scalar-to-matrix deserialiser with valid/ready on both sides.
// Optional framing check on in_last enabled by defining MAT_COLLECT_FRAMECHK_EN.
module mat_collect #(
  parameter int ROWS = 2,
  parameter int COLS = 2
) (
  fixedp.slave g
);
  // 1-based indices need enough bits to hold COLS/ROWS themselves.
  localparam int XW = (COLS < 2) ? 1 : $clog2(COLS + 1);
  localparam int YW = (ROWS < 2) ? 1 : $clog2(ROWS + 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic          out_valid_n;
  logic          wr_en;
  logic          in_fire;
  logic          out_fire;
  logic          last_col;
  logic          last_row;

  assign g.in_ready = (state == FILL);
  assign in_fire    = g.in_valid && (state == FILL);
  assign out_fire   = g.out_valid && g.out_ready;
  assign last_col   = (x == XW'(COLS));
  assign last_row   = (y == YW'(ROWS));

  always_comb begin
    state_n     = state;
    x_n         = x;
    y_n         = y;
    out_valid_n = g.out_valid;
    wr_en       = 1'b0;
    case (state)
      FILL: begin
        if (in_fire) begin
          wr_en = 1'b1;
          if (!last_col) begin
            x_n = x + XW'(1);
          end else begin
            x_n = XW'(1);
            if (!last_row) begin
              y_n = y + YW'(1);
            end else begin
              y_n         = YW'(1);
              state_n     = FULL;
              out_valid_n = 1'b1;
            end
          end
        end
      end
      FULL: begin
        if (out_fire) begin
          state_n     = FILL;
          out_valid_n = 1'b0;
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      state       <= FILL;
      x           <= XW'(1);
      y           <= YW'(1);
      g.out_valid <= 1'b0;
      g.o         <= '0;
    end else begin
      state       <= state_n;
      x           <= x_n;
      y           <= y_n;
      g.out_valid <= out_valid_n;
      if (wr_en) begin
        g.o[y][x] <= g.in_data;
      end
    end
  end

`ifdef MAT_COLLECT_FRAMECHK_EN
  // in_last must be high on the final element and only there; err is diagnostic and sticky.
  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      g.err <= 1'b0;
    end else if (in_fire && (g.in_last != (last_col && last_row))) begin
      g.err <= 1'b1;
    end
  end
`else
  assign g.err = 1'b0;
`endif

endmodule
